// File: rtl/ram_moc_interface.sv
// Byte-addressed big-endian data memory with a four-phase mfa/moc handshake
// and a programmable number of wait cycles per access.
module ram_moc_interface #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mfa,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              unSign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       dataIn,
    output logic [31:0]       dataOut,
    output logic              moc,
    output logic              addrErr,
    output logic              busy
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              rwQ;
    logic [1:0]        sizeQ;
    logic              unSignQ;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0]       dataQ;

    logic [7:0] mem [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0] addr1, addr2, addr3;
    logic              isByte, isHalf, misaligned, lastCycle, doWrite;
    logic [31:0]       readData;

    always_comb begin
        addr1      = addrQ + ADDR_W'(1);
        addr2      = addrQ + ADDR_W'(2);
        addr3      = addrQ + ADDR_W'(3);
        isByte     = (sizeQ == 2'b00);
        isHalf     = (sizeQ == 2'b01);
        misaligned = (isHalf && addrQ[0]) || (sizeQ[1] && (addrQ[1:0] != 2'b00));
        lastCycle  = (state == BUSY) && (cnt == CW'(WAIT_CYCLES));
        doWrite    = lastCycle && !rwQ && !misaligned && !reset;
    end

    always_comb begin
        readData = '0;
        if (isByte)
            readData = {{24{mem[addrQ][7] & ~unSignQ}}, mem[addrQ]};
        else if (isHalf)
            readData = {{16{mem[addrQ][7] & ~unSignQ}}, mem[addrQ], mem[addr1]};
        else
            readData = {mem[addrQ], mem[addr1], mem[addr2], mem[addr3]};
    end

    // Memory has no reset; an aborted request never reaches its last BUSY cycle.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            if (isByte) begin
                mem[addrQ] <= dataQ[7:0];
            end else if (isHalf) begin
                mem[addrQ] <= dataQ[15:8];
                mem[addr1] <= dataQ[7:0];
            end else begin
                mem[addrQ] <= dataQ[31:24];
                mem[addr1] <= dataQ[23:16];
                mem[addr2] <= dataQ[15:8];
                mem[addr3] <= dataQ[7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            moc     <= 1'b0;
            addrErr <= 1'b0;
            busy    <= 1'b0;
            dataOut <= '0;
            rwQ     <= 1'b0;
            sizeQ   <= '0;
            unSignQ <= 1'b0;
            addrQ   <= '0;
            dataQ   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mfa) begin
                        rwQ     <= rw;
                        sizeQ   <= size;
                        unSignQ <= unSign;
                        addrQ   <= addr;
                        dataQ   <= dataIn;
                        addrErr <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CW'(WAIT_CYCLES)) begin
                        moc     <= 1'b1;
                        addrErr <= misaligned;
                        if (rwQ && !misaligned)
                            dataOut <= readData;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!mfa) begin
                        moc   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_moc_interface.sv
// Directed bench: two instances (WAIT_CYCLES 2 and 0) driven by the same
// request stream; vector table plus handshake and abort sequences.
module tb_ram_moc_interface;

    logic        clk = 1'b0;
    logic        rst, rst0;
    logic        mfa, rw, unSign;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] dataIn;
    logic [31:0] dataOut, dataOut0;
    logic        moc, moc0, addrErr, addrErr0, busy, busy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_moc_interface #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(rst), .mfa(mfa), .rw(rw), .size(size), .unSign(unSign),
        .addr(addr), .dataIn(dataIn), .dataOut(dataOut), .moc(moc),
        .addrErr(addrErr), .busy(busy)
    );

    ram_moc_interface #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst0), .mfa(mfa), .rw(rw), .size(size), .unSign(unSign),
        .addr(addr), .dataIn(dataIn), .dataOut(dataOut0), .moc(moc0),
        .addrErr(addrErr0), .busy(busy0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic [1:0]  s;
        logic        u;
        logic [8:0]  a;
        logic [31:0] d;
        logic [31:0] expOut;
        logic        expErr;
    } vec_t;

    // One full handshake; called just after a falling edge, returns after one.
    task automatic access(input logic r, input logic [1:0] s, input logic u,
                          input logic [8:0] a, input logic [31:0] d,
                          input int hold, input bit scramble,
                          output logic [31:0] out, output logic [31:0] out0,
                          output logic err, output logic err0);
        int lat = -1;
        int lat0 = -1;
        bit holdOk = 1'b1;
        rw = r; size = s; unSign = u; addr = a; dataIn = d; mfa = 1'b1;
        for (int e = 1; e <= 20 && lat < 0; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                check("busyRise", {30'd0, busy, busy0}, 32'd3);
                if (scramble) begin
                    rw = 1'b1; size = 2'b10; addr = 9'h018; dataIn = '0;
                end
            end
            if (moc0 && lat0 < 0) lat0 = e - 1;
            if (moc && lat < 0) lat = e - 1;
        end
        check("latency2", lat, 32'd3);
        check("latency0", lat0, 32'd1);
        out = dataOut; out0 = dataOut0; err = addrErr; err0 = addrErr0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (!moc || !moc0 || !busy || dataOut !== out) holdOk = 1'b0;
        end
        if (hold > 0) check("holdMoc", {31'd0, holdOk}, 32'd1);
        @(negedge clk);
        mfa = 1'b0;
        @(posedge clk); #1;
        check("release", {28'd0, moc, moc0, busy, busy0}, 32'd0);
        @(negedge clk);
    endtask

    vec_t vecs[23];
    logic [31:0] o, o0;
    logic e1, e0;
    bit abortOk;

    initial begin
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 2'b10, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 9'h011, 32'h0,        32'hFFFFFFAD, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 1'b1, 9'h011, 32'h0,        32'h000000AD, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, 9'h012, 32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 1'b1, 9'h012, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 9'h013, 32'h00000055, 32'h0000BEEF, 1'b0};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 9'h010, 32'h0,        32'hDEADBE55, 1'b0};
        vecs[8]  = '{1'b1, 2'b00, 1'b1, 9'h010, 32'h0,        32'h000000DE, 1'b0};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 9'h013, 32'h0,        32'h00000055, 1'b0};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 9'h002, 32'h0,        32'h00000055, 1'b1};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 9'h011, 32'h0,        32'h00000055, 1'b1};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 9'h011, 32'hFFFFFFFF, 32'h00000055, 1'b1};
        vecs[13] = '{1'b0, 2'b00, 1'b0, 9'h014, 32'h000000A5, 32'h00000055, 1'b0};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 9'h010, 32'h0,        32'hDEADBE55, 1'b0};
        vecs[15] = '{1'b1, 2'b00, 1'b0, 9'h014, 32'h0,        32'hFFFFFFA5, 1'b0};
        vecs[16] = '{1'b0, 2'b11, 1'b0, 9'h018, 32'h01020304, 32'hFFFFFFA5, 1'b0};
        vecs[17] = '{1'b1, 2'b00, 1'b0, 9'h01B, 32'h0,        32'h00000004, 1'b0};
        vecs[18] = '{1'b0, 2'b01, 1'b0, 9'h018, 32'h0000ABCD, 32'h00000004, 1'b0};
        vecs[19] = '{1'b1, 2'b10, 1'b0, 9'h018, 32'h0,        32'hABCD0304, 1'b0};
        vecs[20] = '{1'b1, 2'b01, 1'b0, 9'h01A, 32'h0,        32'h00000304, 1'b0};
        vecs[21] = '{1'b0, 2'b10, 1'b0, 9'h020, 32'hCAFEF00D, 32'h00000304, 1'b0};
        vecs[22] = '{1'b1, 2'b11, 1'b0, 9'h020, 32'h0,        32'hCAFEF00D, 1'b0};

        rst = 1'b1; rst0 = 1'b1;
        mfa = 1'b0; rw = 1'b0; size = '0; unSign = 1'b0; addr = '0; dataIn = '0;
        repeat (2) @(negedge clk);
        check("resetOut", dataOut | dataOut0, 32'd0);
        check("resetFlags", {26'd0, moc, moc0, addrErr, addrErr0, busy, busy0}, 32'd0);
        rst = 1'b0; rst0 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            access(vecs[i].r, vecs[i].s, vecs[i].u, vecs[i].a, vecs[i].d, 0, 1'b0, o, o0, e1, e0);
            check($sformatf("vec%0d dataOut", i), o, vecs[i].expOut);
            check($sformatf("vec%0d dataOut0", i), o0, vecs[i].expOut);
            check($sformatf("vec%0d addrErr", i), {30'd0, e1, e0}, {30'd0, vecs[i].expErr, vecs[i].expErr});
        end

        // mfa held 5 cycles past moc, request inputs changed while busy
        access(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 5, 1'b1, o, o0, e1, e0);
        check("holdRead", o, 32'hDEADBE55);
        check("holdRead0", o0, 32'hDEADBE55);

        // abort: reset one cycle after capturing a write to 0x020
        abortOk = 1'b1;
        rw = 1'b0; size = 2'b10; unSign = 1'b0; addr = 9'h020; dataIn = 32'h12345678; mfa = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abortAsync", {29'd0, moc, busy, addrErr}, 32'd0);
        check("abortOut", dataOut, 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            if (moc) abortOk = 1'b0;
        end
        check("abortNoMoc", {31'd0, abortOk}, 32'd1);
        @(negedge clk);
        mfa = 1'b0; rst = 1'b0;
        @(negedge clk);

        access(1'b1, 2'b10, 1'b0, 9'h020, 32'h0, 0, 1'b0, o, o0, e1, e0);
        check("abortMem", o, 32'hCAFEF00D);
        check("noAbortMem0", o0, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
